// File: rtl/display_hold_timer_pkg.sv
// ============================================================================
// Module      : display_hold_timer_pkg
// Description : Shared types and constant functions for the display hold
//               timer: IDLE/HOLD state encoding and ceiling-log2 sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_hold_timer_pkg;

  // One-bit state encoding shared by every hold channel.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

  // Ceiling log2, usable in parameter and port-width expressions.
  // clog2(1) = 0, clog2(4) = 2, clog2(6) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Width of a channel index bus; never narrower than one bit so that a
  // single-channel build still has a real select port.
  function automatic int sel_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hold_channel.sv
// ============================================================================
// Module      : hold_channel
// Description : One display hold channel: IDLE/HOLD state machine with a
//               saturating tick counter, trigger/cancel handling and a
//               one-cycle done pulse on natural expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_channel
  import display_hold_timer_pkg::*;
#(
  parameter int HOLD_TICKS = 5,
  parameter int RETRIG     = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic enable_i,
  input  logic trig_i,
  input  logic cancel_i,
  output logic active_o,
  output logic active_next_o,
  output logic trig_accept_o,
  output logic done_o
);

  localparam int              CNT_W  = clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HOLD_TICKS - 1);

  hold_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept_d;

  // Next-state decode. Priority: cancel, then trigger, then counting tick.
  // A tick in the cycle a hold starts is not counted, and a retrigger on
  // the final tick wins over expiry so the hold simply restarts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    accept_d = 1'b0;
    if (cancel_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (trig_i) begin
        state_d  = ST_HOLD;
        cnt_d    = '0;
        accept_d = 1'b1;
      end
    end else if (trig_i && (RETRIG != 0)) begin
      cnt_d    = '0;
      accept_d = 1'b1;
    end else if (tick_i && enable_i) begin
      if (cnt_q == C_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State, counter and done-pulse registers; reset aborts any hold silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign active_o      = (state_q == ST_HOLD);
  assign active_next_o = (state_d == ST_HOLD);
  assign trig_accept_o = accept_d;
  assign done_o        = done_q;

endmodule

`default_nettype wire

// File: rtl/display_hold_timer.sv
// ============================================================================
// Module      : display_hold_timer
// Description : CH independent display hold channels plus the arbitration
//               that picks which channel the display shows (hold_sel) and
//               the data-select flag (hold_control) that is low while any
//               channel holds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_hold_timer
  import display_hold_timer_pkg::*;
#(
  parameter int CH         = 4,
  parameter int HOLD_TICKS = 5,
  parameter int RETRIG     = 1
) (
  input  logic                     hold_clk,
  input  logic                     hold_rst_n,
  input  logic                     hold_tick,
  input  logic                     hold_enable,
  input  logic [CH-1:0]            hold_trig,
  input  logic [CH-1:0]            hold_cancel,
  output logic [CH-1:0]            hold_active,
  output logic [CH-1:0]            hold_done,
  output logic [sel_width(CH)-1:0] hold_sel,
  output logic                     hold_control
);

  localparam int SEL_W = sel_width(CH);

  logic [CH-1:0]    active_d;
  logic [CH-1:0]    trig_acc;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             control_q;
  logic [SEL_W-1:0] trig_low;
  logic [SEL_W-1:0] active_low;
  logic             sel_leaving;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_chan
      hold_channel #(
        .HOLD_TICKS (HOLD_TICKS),
        .RETRIG     (RETRIG)
      ) u_chan (
        .clk_i         (hold_clk),
        .rst_ni        (hold_rst_n),
        .tick_i        (hold_tick),
        .enable_i      (hold_enable),
        .trig_i        (hold_trig[g]),
        .cancel_i      (hold_cancel[g]),
        .active_o      (hold_active[g]),
        .active_next_o (active_d[g]),
        .trig_accept_o (trig_acc[g]),
        .done_o        (hold_done[g])
      );
    end
  endgenerate

  // Find the lowest accepted trigger, the lowest channel that will still be
  // holding after this edge, and whether the shown channel is dropping out.
  always_comb begin
    trig_low    = '0;
    active_low  = '0;
    sel_leaving = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (trig_acc[i]) begin
        trig_low = SEL_W'(i);
      end
      if (active_d[i]) begin
        active_low = SEL_W'(i);
      end
      if (SEL_W'(i) == sel_q) begin
        sel_leaving = hold_active[i] & ~active_d[i];
      end
    end
  end

  // Select update: a new trigger always takes the display; otherwise the
  // display follows the lowest remaining holder, or stays put if none is left.
  always_comb begin
    sel_d = sel_q;
    if (|trig_acc) begin
      sel_d = trig_low;
    end else if (sel_leaving && (|active_d)) begin
      sel_d = active_low;
    end
  end

  // Select and data-select registers, updated on the same edge as the
  // channel states so hold_control tracks hold_active without lag.
  always_ff @(posedge hold_clk or negedge hold_rst_n) begin
    if (!hold_rst_n) begin
      sel_q     <= '0;
      control_q <= 1'b1;
    end else begin
      sel_q     <= sel_d;
      control_q <= ~(|active_d);
    end
  end

  assign hold_sel     = sel_q;
  assign hold_control = control_q;

endmodule

`default_nettype wire

// File: tb/tb_display_hold_timer.sv
// ============================================================================
// Module      : tb_display_hold_timer
// Description : Directed self-checking bench for display_hold_timer. Three
//               builds share one stimulus: A (RETRIG=1, HOLD_TICKS=5),
//               B (RETRIG=0, HOLD_TICKS=5) and C (RETRIG=1, HOLD_TICKS=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_hold_timer;

  logic       hold_clk = 1'b0;
  logic       hold_rst_n;
  logic       hold_tick;
  logic       hold_enable;
  logic [3:0] hold_trig;
  logic [3:0] hold_cancel;

  logic [3:0] act_a, done_a, act_b, done_b, act_c, done_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       ctl_a, ctl_b, ctl_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hold_clk = ~hold_clk;

  display_hold_timer #(.CH(4), .HOLD_TICKS(5), .RETRIG(1)) dut_a (
    .hold_clk(hold_clk), .hold_rst_n(hold_rst_n), .hold_tick(hold_tick),
    .hold_enable(hold_enable), .hold_trig(hold_trig), .hold_cancel(hold_cancel),
    .hold_active(act_a), .hold_done(done_a), .hold_sel(sel_a), .hold_control(ctl_a)
  );

  display_hold_timer #(.CH(4), .HOLD_TICKS(5), .RETRIG(0)) dut_b (
    .hold_clk(hold_clk), .hold_rst_n(hold_rst_n), .hold_tick(hold_tick),
    .hold_enable(hold_enable), .hold_trig(hold_trig), .hold_cancel(hold_cancel),
    .hold_active(act_b), .hold_done(done_b), .hold_sel(sel_b), .hold_control(ctl_b)
  );

  display_hold_timer #(.CH(4), .HOLD_TICKS(1), .RETRIG(1)) dut_c (
    .hold_clk(hold_clk), .hold_rst_n(hold_rst_n), .hold_tick(hold_tick),
    .hold_enable(hold_enable), .hold_trig(hold_trig), .hold_cancel(hold_cancel),
    .hold_active(act_c), .hold_done(done_c), .hold_sel(sel_c), .hold_control(ctl_c)
  );

  // Apply one cycle of inputs, take the edge, then return inputs to idle.
  // Outputs are then read 1 time unit after the active edge.
  task automatic drive(input logic t, input logic [3:0] tr, input logic [3:0] ca);
    hold_tick   = t;
    hold_trig   = tr;
    hold_cancel = ca;
    @(posedge hold_clk);
    #1;
    hold_tick   = 1'b0;
    hold_trig   = 4'b0000;
    hold_cancel = 4'b0000;
  endtask

  task automatic do_reset();
    hold_rst_n  = 1'b0;
    hold_tick   = 1'b0;
    hold_trig   = 4'b0000;
    hold_cancel = 4'b0000;
    hold_enable = 1'b1;
    repeat (2) @(posedge hold_clk);
    #1;
    hold_rst_n = 1'b1;
    @(posedge hold_clk);
    #1;
  endtask

  task automatic test_reset();
    hold_rst_n  = 1'b0;
    hold_tick   = 1'b0;
    hold_trig   = 4'b0000;
    hold_cancel = 4'b0000;
    hold_enable = 1'b1;
    repeat (2) @(posedge hold_clk);
    #1;
    n_cmp++; if (act_a !== 4'b0000) begin n_err++; $display("FAIL reset_active: got %b want 0000", act_a); end
    n_cmp++; if (done_a !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b want 0000", done_a); end
    n_cmp++; if (sel_a !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
    n_cmp++; if (ctl_a !== 1'b1) begin n_err++; $display("FAIL reset_control: got %b want 1", ctl_a); end
    n_cmp++; if (ctl_c !== 1'b1 || act_c !== 4'b0000) begin n_err++; $display("FAIL reset_c: got ctl %b act %b want 1 0000", ctl_c, act_c); end
    hold_rst_n = 1'b1;
    @(posedge hold_clk);
    #1;
  endtask

  // One hold on channel 2, ticks separated by idle cycles.
  task automatic test_basic();
    do_reset();
    drive(1'b0, 4'b0100, 4'b0000);
    n_cmp++; if (act_a !== 4'b0100) begin n_err++; $display("FAIL basic_start_active: got %b want 0100", act_a); end
    n_cmp++; if (ctl_a !== 1'b0) begin n_err++; $display("FAIL basic_start_control: got %b want 0", ctl_a); end
    n_cmp++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL basic_start_sel: got %0d want 2", sel_a); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 4'b0000, 4'b0000);
      n_cmp++; if (act_a !== 4'b0100) begin n_err++; $display("FAIL basic_idle_active k=%0d: got %b want 0100", k, act_a); end
      drive(1'b1, 4'b0000, 4'b0000);
      n_cmp++; if (act_a !== ((k < 5) ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL basic_tick_active k=%0d: got %b", k, act_a); end
      n_cmp++; if (done_a !== ((k == 5) ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL basic_tick_done k=%0d: got %b", k, done_a); end
      n_cmp++; if (ctl_a !== ((k == 5) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL basic_tick_control k=%0d: got %b", k, ctl_a); end
    end
    drive(1'b0, 4'b0000, 4'b0000);
    n_cmp++; if (done_a !== 4'b0000) begin n_err++; $display("FAIL basic_done_width: got %b want 0000", done_a); end
    n_cmp++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL basic_sel_kept: got %0d want 2", sel_a); end
  endtask

  // trig, 3 ticks, trig, 5 ticks: A expires on tick 8, B on tick 5.
  task automatic test_retrig();
    do_reset();
    drive(1'b0, 4'b0001, 4'b0000);
    for (int k = 1; k <= 3; k++) drive(1'b1, 4'b0000, 4'b0000);
    n_cmp++; if (act_a !== 4'b0001 || act_b !== 4'b0001) begin n_err++; $display("FAIL retrig_mid: got a %b b %b want 0001 0001", act_a, act_b); end
    drive(1'b0, 4'b0001, 4'b0000);
    n_cmp++; if (done_a !== 4'b0000 || act_a !== 4'b0001) begin n_err++; $display("FAIL retrig_accept: got act %b done %b", act_a, done_a); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'b0000, 4'b0000);
      n_cmp++; if (act_a !== ((k < 5) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL retrig_a_active k=%0d: got %b", k, act_a); end
      n_cmp++; if (done_a !== ((k == 5) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL retrig_a_done k=%0d: got %b", k, done_a); end
      n_cmp++; if (act_b !== ((k < 2) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL noretrig_b_active k=%0d: got %b", k, act_b); end
      n_cmp++; if (done_b !== ((k == 2) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL noretrig_b_done k=%0d: got %b", k, done_b); end
    end
  endtask

  // Retrigger coincident with the expiry tick: A restarts, B expires.
  task automatic test_retrig_on_expiry();
    do_reset();
    drive(1'b0, 4'b0001, 4'b0000);
    for (int k = 1; k <= 4; k++) drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0001, 4'b0000);
    n_cmp++; if (act_a !== 4'b0001 || done_a !== 4'b0000) begin n_err++; $display("FAIL expiry_retrig_a: got act %b done %b want 0001 0000", act_a, done_a); end
    n_cmp++; if (act_b !== 4'b0000 || done_b !== 4'b0001) begin n_err++; $display("FAIL expiry_retrig_b: got act %b done %b want 0000 0001", act_b, done_b); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'b0000, 4'b0000);
      n_cmp++; if (done_a !== ((k == 5) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL expiry_restart_done k=%0d: got %b", k, done_a); end
    end
  endtask

  // Simultaneous triggers and cancel-driven select movement.
  task automatic test_sel();
    do_reset();
    drive(1'b0, 4'b1010, 4'b0000);
    n_cmp++; if (sel_a !== 2'd1) begin n_err++; $display("FAIL sel_pair: got %0d want 1", sel_a); end
    n_cmp++; if (act_a !== 4'b1010) begin n_err++; $display("FAIL sel_pair_active: got %b want 1010", act_a); end
    drive(1'b0, 4'b0000, 4'b0010);
    n_cmp++; if (sel_a !== 2'd3) begin n_err++; $display("FAIL sel_cancel_move: got %0d want 3", sel_a); end
    n_cmp++; if (act_a !== 4'b1000 || done_a !== 4'b0000) begin n_err++; $display("FAIL sel_cancel_state: got act %b done %b want 1000 0000", act_a, done_a); end
    drive(1'b0, 4'b0000, 4'b1000);
    n_cmp++; if (sel_a !== 2'd3 || ctl_a !== 1'b1) begin n_err++; $display("FAIL sel_none_left: got sel %0d ctl %b want 3 1", sel_a, ctl_a); end
    n_cmp++; if (done_a !== 4'b0000) begin n_err++; $display("FAIL sel_cancel_done: got %b want 0000", done_a); end
  endtask

  // Enable low for 3 ticks mid-hold; a trigger is still accepted meanwhile.
  task automatic test_enable();
    do_reset();
    drive(1'b0, 4'b0001, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0000);
    hold_enable = 1'b0;
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0010, 4'b0000);
    n_cmp++; if (act_a !== 4'b0011 || sel_a !== 2'd1) begin n_err++; $display("FAIL en_trig_accept: got act %b sel %0d want 0011 1", act_a, sel_a); end
    drive(1'b1, 4'b0000, 4'b0000);
    n_cmp++; if (act_a !== 4'b0011 || done_a !== 4'b0000) begin n_err++; $display("FAIL en_frozen: got act %b done %b want 0011 0000", act_a, done_a); end
    hold_enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'b0000, 4'b0000);
      n_cmp++; if (act_a !== ((k < 3) ? 4'b0011 : (k < 5) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL en_active k=%0d: got %b", k, act_a); end
      n_cmp++; if (done_a !== ((k == 3) ? 4'b0001 : (k == 5) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL en_done k=%0d: got %b", k, done_a); end
    end
    n_cmp++; if (sel_a !== 2'd1 || ctl_a !== 1'b1) begin n_err++; $display("FAIL en_end: got sel %0d ctl %b want 1 1", sel_a, ctl_a); end
    drive(1'b0, 4'b0100, 4'b0100);
    n_cmp++; if (act_a !== 4'b0000 || ctl_a !== 1'b1 || sel_a !== 2'd1) begin n_err++; $display("FAIL trig_cancel_same: got act %b ctl %b sel %0d want 0000 1 1", act_a, ctl_a, sel_a); end
  endtask

  // Asynchronous reset at count 3, then nothing until a fresh trigger.
  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 4'b0100, 4'b0000);
    for (int k = 1; k <= 3; k++) drive(1'b1, 4'b0000, 4'b0000);
    #2;
    hold_rst_n = 1'b0;
    #1;
    n_cmp++; if (act_a !== 4'b0000 || done_a !== 4'b0000) begin n_err++; $display("FAIL async_rst_state: got act %b done %b want 0000 0000", act_a, done_a); end
    n_cmp++; if (sel_a !== 2'd0 || ctl_a !== 1'b1) begin n_err++; $display("FAIL async_rst_sel_ctl: got sel %0d ctl %b want 0 1", sel_a, ctl_a); end
    @(posedge hold_clk);
    #1;
    hold_rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'b0000, 4'b0000);
      n_cmp++; if (act_a !== 4'b0000 || done_a !== 4'b0000) begin n_err++; $display("FAIL post_rst_quiet k=%0d: got act %b done %b", k, act_a, done_a); end
    end
    drive(1'b0, 4'b0100, 4'b0000);
    n_cmp++; if (act_a !== 4'b0100) begin n_err++; $display("FAIL post_rst_trig: got %b want 0100", act_a); end
  endtask

  // HOLD_TICKS=1: tick on the trigger cycle is ignored, next tick expires.
  task automatic test_h1();
    do_reset();
    drive(1'b1, 4'b0001, 4'b0000);
    n_cmp++; if (act_c !== 4'b0001 || done_c !== 4'b0000) begin n_err++; $display("FAIL h1_start: got act %b done %b want 0001 0000", act_c, done_c); end
    drive(1'b1, 4'b0000, 4'b0000);
    n_cmp++; if (act_c !== 4'b0000 || done_c !== 4'b0001) begin n_err++; $display("FAIL h1_expire: got act %b done %b want 0000 0001", act_c, done_c); end
    drive(1'b0, 4'b0000, 4'b0000);
    n_cmp++; if (done_c !== 4'b0000) begin n_err++; $display("FAIL h1_done_width: got %b want 0000", done_c); end
  endtask

  initial begin
    hold_rst_n  = 1'b0;
    hold_tick   = 1'b0;
    hold_enable = 1'b1;
    hold_trig   = 4'b0000;
    hold_cancel = 4'b0000;
    test_reset();
    test_basic();
    test_retrig();
    test_retrig_on_expiry();
    test_sel();
    test_enable();
    test_reset_mid();
    test_h1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
